// File: rtl/sdram_port_arbiter_if.sv
// Avalon-MM style port bundle (active-low strobes) shared by both requesters and the SDRAM slave side.
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 16
);
  logic              read_n;
  logic              write_n;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic              readdatavalid;
  logic [DATA_W-1:0] readdata;

  modport master (
    output read_n, write_n, address, writedata,
    input  waitrequest, readdatavalid, readdata
  );

  modport slave (
    input  read_n, write_n, address, writedata,
    output waitrequest, readdatavalid, readdata
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one 16-bit Avalon-MM SDRAM port between two requesters.
// One cycle from request to slave strobe; slave stalls pass through, reads also stall while the tag FIFO is full.
module sdram_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 16,
  parameter int MAX_PENDING = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sdram_port_arbiter_if.slave  r0,
  sdram_port_arbiter_if.slave  r1,
  sdram_port_arbiter_if.master s,
  output logic                 s_chipselect,
  output logic [1:0]           s_byteenable,
  output logic                 proto_err
);
  localparam int PTR_W = $clog2(MAX_PENDING);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(MAX_PENDING);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t                 state, state_nxt;
  logic                   rr_ptr, rr_ptr_nxt;
  logic [MAX_PENDING-1:0] tag_mem;
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [PTR_W:0]         count;

  logic rd0, wr0, rd1, wr1, elig0, elig1, full;
  logic grant, sel, g_rd, g_wr, g_rd_eff, g_wr_eff, rd_held;
  logic accept, push, pop, head_tag;

  assign rd0   = !r0.read_n;
  assign wr0   = !r0.write_n;
  assign rd1   = !r1.read_n;
  assign wr1   = !r1.write_n;
  assign full  = (count == FULL_CNT);
  // A read (including a double strobe) needs a free tag; a plain write never does.
  assign elig0 = rd0 ? !full : wr0;
  assign elig1 = rd1 ? !full : wr1;

  assign grant    = (state != IDLE);
  assign sel      = (state == GRANT1);
  assign g_rd     = sel ? rd1 : rd0;
  assign g_wr     = sel ? wr1 : wr0;
  assign rd_held  = g_rd && full;
  assign g_rd_eff = g_rd && !full;
  assign g_wr_eff = g_wr && !g_rd;
  assign accept   = grant && (g_rd_eff || g_wr_eff) && !s.waitrequest;

  assign push     = accept && g_rd_eff;
  assign pop      = s.readdatavalid && (count != '0);
  assign head_tag = tag_mem[rd_ptr];

  assign r0.readdatavalid = pop && !head_tag;
  assign r1.readdatavalid = pop && head_tag;
  assign r0.readdata      = s.readdata;
  assign r1.readdata      = s.readdata;
  assign s_chipselect     = 1'b1;
  assign s_byteenable     = 2'b11;

  always_comb begin
    state_nxt      = state;
    rr_ptr_nxt     = rr_ptr;
    s.read_n       = 1'b1;
    s.write_n      = 1'b1;
    s.address      = {ADDR_W{1'b0}};
    s.writedata    = {DATA_W{1'b0}};
    r0.waitrequest = 1'b1;
    r1.waitrequest = 1'b1;
    case (state)
      IDLE: begin
        if (elig0 && elig1)
          state_nxt = rr_ptr ? GRANT1 : GRANT0;
        else if (elig0)
          state_nxt = GRANT0;
        else if (elig1)
          state_nxt = GRANT1;
      end
      GRANT0, GRANT1: begin
        s.read_n    = !g_rd_eff;
        s.write_n   = !g_wr_eff;
        s.address   = sel ? r1.address : r0.address;
        s.writedata = sel ? r1.writedata : r0.writedata;
        if (sel)
          r1.waitrequest = s.waitrequest | rd_held;
        else
          r0.waitrequest = s.waitrequest | rd_held;
        if (accept) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = !sel;
        end else if (!g_rd && !g_wr) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      tag_mem   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      proto_err <= 1'b0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
      if (push) begin
        tag_mem[wr_ptr] <= sel;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)
        count <= count + (PTR_W+1)'(1);
      else if (pop && !push)
        count <= count - (PTR_W+1)'(1);
      // Double strobe from the granted requester, or return data with no owner.
      if ((grant && g_rd && g_wr) || (s.readdatavalid && (count == '0)))
        proto_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench: requester-side acceptances predict slave transfers; slave reads predict routed return data.
module tb_sdram_port_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 16;
  localparam int MAX_PENDING = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sdram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) r0_if ();
  sdram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) r1_if ();
  sdram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_if ();
  logic       s_chipselect;
  logic [1:0] s_byteenable;
  logic       proto_err;

  sdram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PENDING(MAX_PENDING)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .r0           (r0_if),
    .r1           (r1_if),
    .s            (s_if),
    .s_chipselect (s_chipselect),
    .s_byteenable (s_byteenable),
    .proto_err    (proto_err)
  );

  logic              rq_read_n [2];
  logic              rq_write_n[2];
  logic [ADDR_W-1:0] rq_addr   [2];
  logic [DATA_W-1:0] rq_wdata  [2];
  logic              wq[2];
  logic              rv[2];
  logic              s_wait, s_rdv;
  logic [DATA_W-1:0] s_rdata;

  assign r0_if.read_n    = rq_read_n[0];
  assign r0_if.write_n   = rq_write_n[0];
  assign r0_if.address   = rq_addr[0];
  assign r0_if.writedata = rq_wdata[0];
  assign r1_if.read_n    = rq_read_n[1];
  assign r1_if.write_n   = rq_write_n[1];
  assign r1_if.address   = rq_addr[1];
  assign r1_if.writedata = rq_wdata[1];
  assign wq[0] = r0_if.waitrequest;
  assign wq[1] = r1_if.waitrequest;
  assign rv[0] = r0_if.readdatavalid;
  assign rv[1] = r1_if.readdatavalid;
  assign s_if.waitrequest   = s_wait;
  assign s_if.readdatavalid = s_rdv;
  assign s_if.readdata      = s_rdata;

  typedef struct { bit owner; bit is_rd; logic [31:0] addr; logic [15:0] data; } xfer_t;
  typedef struct { bit owner; logic [15:0] data; } ret_t;
  typedef struct { int due; logic [15:0] data; } slv_t;

  xfer_t exp_q[$];      // transfers the requesters saw accepted, in order
  ret_t  exp_ret[$];    // outstanding reads: who issued them and what data comes back
  slv_t  ret_q[$];      // slave model's pending read returns
  bit    grant_log[$];
  int    wr_acc = 0;
  int    cyc = 0;

  int wait_mode = 0;    // 0 never stall, 1 random stall, 2 always stall
  int lat_min = 1, lat_max = 1;
  int ret_budget = -1;  // -1 unlimited returns
  int force_data = -1;
  bit orphan_req = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Slave model: stall pattern and in-order read returns.
  initial begin
    s_wait = 1'b1; s_rdv = 1'b0; s_rdata = '0;
    forever begin
      @(posedge clk); #3;
      case (wait_mode)
        0:       s_wait = 1'b0;
        1:       s_wait = ($urandom_range(0, 9) < 3);
        default: s_wait = 1'b1;
      endcase
      s_rdv   = 1'b0;
      s_rdata = 16'($urandom);
      if (orphan_req) begin
        s_rdv = 1'b1; s_rdata = 16'hDEAD; orphan_req = 1'b0;
      end else if (ret_q.size() > 0 && ret_budget != 0 && ret_q[0].due <= cyc) begin
        s_rdv   = 1'b1;
        s_rdata = ret_q[0].data;
        void'(ret_q.pop_front());
        if (ret_budget > 0) ret_budget--;
      end
    end
  end

  // Monitor: checks every slave transfer and every read return against the scoreboard.
  initial begin
    xfer_t e; ret_t r; slv_t sv; logic [15:0] d;
    forever begin
      @(negedge clk); #2;
      if (!s_if.read_n && !s_if.write_n) fail("both slave strobes low");
      if ((!s_if.read_n || !s_if.write_n) && !s_wait) begin
        if (exp_q.size() == 0) fail("unexpected slave transfer");
        else begin
          e = exp_q.pop_front();
          chk("xfer address", s_if.address, e.addr);
          chk("xfer is_read", !s_if.read_n, e.is_rd);
          grant_log.push_back(e.owner);
          if (e.is_rd) begin
            d = (force_data >= 0) ? force_data[15:0] : 16'($urandom);
            sv.due  = cyc + int'($urandom_range(lat_min, lat_max));
            sv.data = d;
            ret_q.push_back(sv);
            exp_ret.push_back('{owner: e.owner, data: d});
          end else begin
            chk("xfer writedata", s_if.writedata, e.data);
            wr_acc++;
          end
        end
      end
      if (s_rdv) begin
        if (exp_ret.size() > 0) begin
          r = exp_ret.pop_front();
          chk("ret r0 valid", rv[0], !r.owner);
          chk("ret r1 valid", rv[1], r.owner);
          chk("ret data", r.owner ? r1_if.readdata : r0_if.readdata, r.data);
        end else begin
          chk("orphan r0 valid", rv[0], 1'b0);
          chk("orphan r1 valid", rv[1], 1'b0);
        end
      end else if (rv[0] || rv[1]) begin
        fail("readdatavalid without slave data");
      end
    end
  end

  // Called at posedge+1; holds the request until the requester sees it accepted.
  task automatic issue(input int x, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [15:0] d, input int tmo);
    xfer_t e;
    rq_read_n[x] = !rd; rq_write_n[x] = !wr; rq_addr[x] = a; rq_wdata[x] = d;
    for (int i = 0; i < tmo; i++) begin
      @(negedge clk);
      if (!wq[x]) begin
        e.owner = (x == 1); e.is_rd = rd; e.addr = a; e.data = d;
        exp_q.push_back(e);
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    fail("accept timeout");
  endtask

  task automatic idle(input int x);
    rq_read_n[x] = 1'b1; rq_write_n[x] = 1'b1;
  endtask

  task automatic drain();
    @(posedge clk); #1;
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0 && exp_ret.size() == 0 && ret_q.size() == 0) return;
      @(posedge clk); #1;
    end
    fail("drain timeout");
  endtask

  task automatic do_reset();
    @(posedge clk); #1; reset_n = 1'b0;
    @(posedge clk); #1; reset_n = 1'b1;
  endtask

  task automatic rand_req(input int x, input int n);
    for (int i = 0; i < n; i++) begin
      int kind; int gap; bit rd; bit wr;
      kind = $urandom_range(0, 9);
      rd = (kind <= 5) || (kind == 9);
      wr = (kind >= 6);
      issue(x, rd, wr, $urandom, 16'($urandom), 400);
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        idle(x);
        repeat (gap) begin @(posedge clk); #1; end
      end
    end
    idle(x);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    xfer_t e; int t0; bit got; bit done; int wd0;
    for (int i = 0; i < 2; i++) begin
      rq_read_n[i] = 1'b1; rq_write_n[i] = 1'b1; rq_addr[i] = '0; rq_wdata[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset s_read_n", s_if.read_n, 1'b1);
    chk("reset s_write_n", s_if.write_n, 1'b1);
    chk("reset s_address", s_if.address, 32'd0);
    chk("reset s_writedata", s_if.writedata, 16'd0);
    chk("reset r0 waitrequest", wq[0], 1'b1);
    chk("reset r1 waitrequest", wq[1], 1'b1);
    chk("reset r0 readdatavalid", rv[0], 1'b0);
    chk("reset r1 readdatavalid", rv[1], 1'b0);
    chk("reset proto_err", proto_err, 1'b0);
    chk("chipselect", s_chipselect, 1'b1);
    chk("byteenable", s_byteenable, 2'b11);
    @(posedge clk); #1; reset_n = 1'b1;

    // Single read from r0.
    @(posedge clk); #1;
    force_data = 16'hABCD; lat_min = 3; lat_max = 3;
    rq_read_n[0] = 1'b0; rq_addr[0] = 32'd600000;
    @(negedge clk);
    chk("t1 no strobe in request cycle", s_if.read_n, 1'b1);
    chk("t1 r0 waits in idle", wq[0], 1'b1);
    @(negedge clk);
    chk("t1 s_read_n", s_if.read_n, 1'b0);
    chk("t1 s_address", s_if.address, 32'd600000);
    chk("t1 r0 waitrequest", wq[0], 1'b0);
    chk("t1 r1 waitrequest", wq[1], 1'b1);
    e = '{owner: 1'b0, is_rd: 1'b1, addr: 32'd600000, data: 16'h0};
    exp_q.push_back(e);
    @(posedge clk); #1; idle(0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rv[0]) begin
        got = 1'b1;
        chk("t1 readdata", r0_if.readdata, 16'hABCD);
        chk("t1 r1 stays idle", rv[1], 1'b0);
      end
    end
    if (!got) fail("t1 read return timeout");
    force_data = -1;

    // Contention: both hold reads, slave never stalls.
    drain();
    lat_min = 2; lat_max = 2;
    grant_log.delete();
    t0 = cyc;
    fork
      begin for (int i = 0; i < 4; i++) issue(0, 1'b1, 1'b0, 32'h1000 + i, 16'h0, 50); idle(0); end
      begin for (int j = 0; j < 4; j++) issue(1, 1'b1, 1'b0, 32'h2000 + j, 16'h0, 50); idle(1); end
    join
    chk("t2 eight reads in 16 cycles", (cyc - t0) <= 16, 1'b1);
    chk("t2 grant count", grant_log.size(), 8);
    for (int i = 1; i < grant_log.size(); i++)
      chk("t2 grants alternate", grant_log[i] != grant_log[i-1], 1'b1);

    // Stall hold on an r1 write while r0 waits.
    drain();
    wd0 = wr_acc;
    wait_mode = 2;
    rq_write_n[1] = 1'b0; rq_addr[1] = 32'd400000; rq_wdata[1] = 16'h1234;
    @(negedge clk);
    @(posedge clk); #1;
    done = 1'b0;
    fork
      begin issue(0, 1'b1, 1'b0, 32'h3000, 16'h0, 100); idle(0); done = 1'b1; end
    join_none
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3 s_write_n held", s_if.write_n, 1'b0);
      chk("t3 s_address", s_if.address, 32'd400000);
      chk("t3 r1 stalled", wq[1], 1'b1);
      chk("t3 r0 blocked", wq[0], 1'b1);
    end
    wait_mode = 0;
    @(negedge clk);
    chk("t3 r1 released", wq[1], 1'b0);
    e = '{owner: 1'b1, is_rd: 1'b0, addr: 32'd400000, data: 16'h1234};
    exp_q.push_back(e);
    @(posedge clk); #1; idle(1);
    for (int i = 0; i < 50 && !done; i++) begin @(posedge clk); #1; end
    if (!done) fail("t3 r0 read never accepted");
    chk("t3 exactly one write", wr_acc - wd0, 1);

    // Tag FIFO full: fifth read held until a return frees a slot.
    drain();
    ret_budget = 0; lat_min = 1; lat_max = 1;
    for (int i = 0; i < 4; i++) issue(0, 1'b1, 1'b0, 32'h4000 + i, 16'h0, 20);
    idle(0);
    rq_read_n[1] = 1'b0; rq_addr[1] = 32'h5000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4 read held s_read_n", s_if.read_n, 1'b1);
      chk("t4 read held waitrequest", wq[1], 1'b1);
    end
    @(posedge clk); #1; ret_budget = 1;
    issue(1, 1'b1, 1'b0, 32'h5000, 16'h0, 3);
    idle(1);
    ret_budget = -1;

    // Orphan return, then double strobe.
    drain();
    chk("t5 proto_err clean", proto_err, 1'b0);
    orphan_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t5 proto_err after orphan", proto_err, 1'b1);
    do_reset();
    chk("t5 proto_err cleared by reset", proto_err, 1'b0);
    issue(0, 1'b1, 1'b1, 32'h6000, 16'h5555, 20);
    idle(0);
    @(negedge clk);
    chk("t5 proto_err after double strobe", proto_err, 1'b1);

    // Reset with two tags pending and a read on the bus.
    drain();
    do_reset();
    ret_budget = 0;
    issue(0, 1'b1, 1'b0, 32'h7000, 16'h0, 20); idle(0);
    issue(1, 1'b1, 1'b0, 32'h7100, 16'h0, 20); idle(1);
    wait_mode = 2;
    rq_read_n[1] = 1'b0; rq_addr[1] = 32'h7200;
    @(negedge clk);
    @(negedge clk);
    chk("t6 third read on bus", s_if.read_n, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    chk("t6 reset s_read_n", s_if.read_n, 1'b1);
    chk("t6 reset s_address", s_if.address, 32'd0);
    chk("t6 reset r1 waitrequest", wq[1], 1'b1);
    chk("t6 reset r0 waitrequest", wq[0], 1'b1);
    exp_ret.delete();
    idle(1);
    @(posedge clk); #1;
    reset_n = 1'b1; wait_mode = 0;
    chk("t6 proto_err after reset", proto_err, 1'b0);
    ret_budget = -1;
    drain();
    @(negedge clk);
    chk("t6 late data flags proto_err", proto_err, 1'b1);

    // Randomized traffic with random stalls and return latency.
    do_reset();
    wait_mode = 1; lat_min = 1; lat_max = 6;
    fork
      rand_req(0, 40);
      rand_req(1, 40);
    join
    wait_mode = 0;
    drain();
    chk("end no unmatched transfers", exp_q.size(), 0);
    chk("end no missing returns", exp_ret.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Two-requester round-robin arbiter for the single 16-bit Avalon-MM SDRAM master port.
- Lets two layer engines (e.g. layer 1 and layer 2 compute blocks) share SDRAM without modification, since each engine keeps its own active-low read_n/write_n, waitrequest and readdatavalid handshake.
- Tracks outstanding reads in an in-order tag FIFO so that each returning readdatavalid is routed to the requester that issued the read.
- Sits between the engines and the SDRAM controller slave.

Parameters:
ADDR_W, 32, address width
DATA_W, 16, data width
MAX_PENDING, 4, outstanding-read tag FIFO depth (power of 2, >=2)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
r0_read_n  in  1  requester 0 read request, active low
r0_write_n  in  1  requester 0 write request, active low
r0_address  in  ADDR_W  requester 0 address
r0_writedata  in  DATA_W  requester 0 write data
r0_waitrequest  out  1  stall to requester 0
r0_readdatavalid  out  1  read data valid for requester 0
r0_readdata  out  DATA_W  read data to requester 0
r1_*  same seven ports for requester 1
s_read_n  out  1  to SDRAM slave
s_write_n  out  1  to SDRAM slave
s_address  out  ADDR_W  to SDRAM slave
s_writedata  out  DATA_W  to SDRAM slave
s_chipselect  out  1  constant 1
s_byteenable  out  2  constant 2'b11
s_waitrequest  in  1  from SDRAM slave
s_readdatavalid  in  1  from SDRAM slave
s_readdata  in  DATA_W  from SDRAM slave
proto_err  out  1  sticky protocol-error flag

Behaviour:
- Reset (async, reset_n=0):
  - State=IDLE; rr_ptr=0; tag FIFO empty (count=0); proto_err=0.
  - s_read_n=1, s_write_n=1; s_address=0; s_writedata=0.
  - rX_waitrequest=1; rX_readdatavalid=0.
  - Reset mid-transaction discards all pending tags; slave data arriving after reset is treated as orphan (see below).
- Request definition: reqX = !rX_read_n | !rX_write_n. A requester is read-eligible only if count<MAX_PENDING; write-eligible always.
- State machine: IDLE, GRANT0, GRANT1.
  - IDLE: slave strobes deasserted; both rX_waitrequest=1. If exactly one eligible requester is active, go to its GRANT state. If both are active, go to GRANT(rr_ptr). If none, stay IDLE.
  - GRANTx:
    - Slave outputs follow requester x combinationally (read_n, write_n, address, writedata).
    - rx_waitrequest = s_waitrequest; the other requester's waitrequest=1.
    - Acceptance = active strobe and s_waitrequest=0. On acceptance: rr_ptr <= ~x; go to IDLE; if a read, push tag x.
    - If requester x deasserts both strobes before acceptance: go to IDLE, rr_ptr unchanged.
    - If the tag FIFO is full and x presents a read: s_read_n is forced to 1 and rx_waitrequest=1 until a pop frees a slot; no state change.
- Latency: request to slave strobe is 1 cycle (the IDLE->GRANT registration). Minimum 2 cycles per accepted transfer; back-to-back requests from the two requesters alternate.
- Both strobes low from one requester: serviced as a read, write ignored, proto_err <= 1.
- Read return:
  - r0_readdata = r1_readdata = s_readdata (broadcast).
  - On s_readdatavalid=1 with count>0: pop head tag; r(head)_readdatavalid=1 for that same cycle (combinational from the head).
  - Simultaneous push and pop: count unchanged; pointers both advance.
  - s_readdatavalid=1 with count=0: dropped, no rX_readdatavalid, proto_err <= 1.
- Pointer arithmetic: rd/wr pointers are log2(MAX_PENDING) bits and wrap modulo MAX_PENDING; count is log2(MAX_PENDING)+1 bits.
- proto_err clears only on reset.

Test Plan:
- Single requester read: r0 read addr 600000, slave waitrequest=0 on first GRANT cycle, readdatavalid 3 cycles later with 16'hABCD -> s_address=600000 one cycle after request, r0_readdatavalid=1 with 16'hABCD, r1_readdatavalid stays 0, count returns to 0.
- Contention: r0 and r1 both hold reads continuously, slave never stalls -> grants alternate 0,1,0,1 on slave; returned data tagged in the same order; 8 accepted reads in 16 cycles.
- Stall hold: r1 write to 400000 with data 16'h1234, s_waitrequest=1 for 5 cycles -> r1_waitrequest=1 for 5 cycles, r0 request stays blocked, exactly one slave write accepted.
- FIFO full: 4 reads accepted with no return -> 5th read held (s_read_n=1, requester waitrequest=1); one readdatavalid -> 5th read issued next GRANT cycle.
- Orphan data / double strobe: s_readdatavalid pulse with count=0 -> no requester valid, proto_err=1; separate run with r0 read_n=write_n=0 -> read issued, proto_err=1.
- Reset mid-read: assert reset_n=0 with 2 tags pending -> outputs at reset values immediately; after release, count=0, late readdatavalid raises proto_err.
